mem_lsu: RTL and testbench

//  Parametrised memory-access pipeline stage with an integrated load/store unit; sits between EX/MEM and MEM/WB.
//  Non-memory ops pass through combinationally (reg write, HI/LO); loads and stores run a req/ack data-bus transaction.

---
 rtl/mem_lsu.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: memory-access pipeline stage with an integrated load/store unit.
// Non-memory ops pass straight through to MEM/WB; loads and stores run one
// req/ack bus transaction while the upstream stages are held via stall_req_o.
// The EX/MEM register stays frozen during the stall, so the op is decoded
// directly from the (held) inputs rather than from a private copy.
module mem_lsu #(
    parameter int ADDR_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] waddr_reg_i,
    input  logic                  we_reg_i,
    input  logic [31:0]           wdata_i,
    input  logic [31:0]           hi_i,
    input  logic [31:0]           lo_i,
    input  logic                  whilo_i,
    input  logic [3:0]            mem_op_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [31:0]           mem_sdata_i,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [3:0]            bus_sel_o,
    output logic [31:0]           bus_wdata_o,
    input  logic [31:0]           bus_rdata_i,
    input  logic                  bus_ack_i,
    output logic [REG_ADDR_W-1:0] waddr_reg_o,
    output logic                  we_reg_o,
    output logic [31:0]           wdata_o,
    output logic [31:0]           hi_o,
    output logic [31:0]           lo_o,
    output logic                  whilo_o,
    output logic                  stall_req_o,
    output logic                  align_err_o,
    output logic                  timeout_o
);

    // Memory operation encodings on mem_op_i
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

    // Counter just wide enough to hold TIMEOUT_CYC-1
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       load_q, load_d;
    logic              tflag_q, tflag_d;

    logic              is_load;
    logic              is_store;
    logic              is_byte;
    logic              is_half;
    logic              misaligned;
    logic [3:0]        lane_sel;
    logic [31:0]       store_data;
    logic [31:0]       load_fmt;

    // Extract and extend the addressed byte/half from a big-endian word
    function automatic logic [31:0] format_load(input logic [3:0]  op,
                                                input logic [1:0]  a,
                                                input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = d[31:24];
            2'd1:    b = d[23:16];
            2'd2:    b = d[15:8];
            default: b = d[7:0];
        endcase
        h = a[1] ? d[15:0] : d[31:16];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'd0, h};
            default: r = d;
        endcase
        return r;
    endfunction

    // Decode op class, access size, alignment and byte lanes from the held inputs
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_byte    = 1'b0;
        is_half    = 1'b0;
        case (mem_op_i)
            OP_LB, OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
            OP_LW:         begin is_load  = 1'b1; end
            OP_SB:         begin is_store = 1'b1; is_byte = 1'b1; end
            OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:         begin is_store = 1'b1; end
            default:       begin is_load  = 1'b0; end
        endcase

        if (is_byte) begin
            misaligned = 1'b0;
        end else if (is_half) begin
            misaligned = mem_addr_i[0];
        end else begin
            misaligned = (mem_addr_i[1:0] != 2'b00);
        end

        if (is_byte) begin
            lane_sel   = 4'b1000 >> mem_addr_i[1:0];
            store_data = {4{mem_sdata_i[7:0]}};
        end else if (is_half) begin
            lane_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            store_data = {2{mem_sdata_i[15:0]}};
        end else begin
            lane_sel   = 4'b1111;
            store_data = mem_sdata_i;
        end

        load_fmt = format_load(mem_op_i, mem_addr_i[1:0], bus_rdata_i);
    end

    // FSM next state, timeout counter, load capture and all stage outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_d      = load_q;
        tflag_d     = tflag_q;

        waddr_reg_o = waddr_reg_i;
        we_reg_o    = we_reg_i;
        wdata_o     = wdata_i;
        hi_o        = hi_i;
        lo_o        = lo_i;
        whilo_o     = whilo_i;
        stall_req_o = 1'b0;
        align_err_o = 1'b0;
        timeout_o   = 1'b0;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_sel_o   = 4'b0000;
        bus_wdata_o = 32'd0;

        case (state_q)
            IDLE: begin
                if (is_load || is_store) begin
                    if (misaligned) begin
                        align_err_o = 1'b1;
                        we_reg_o    = 1'b0;
                    end else begin
                        stall_req_o = 1'b1;
                        we_reg_o    = 1'b0;
                        whilo_o     = 1'b0;
                        cnt_d       = '0;
                        state_d     = BUSY;
                    end
                end
            end
            BUSY: begin
                bus_req_o   = 1'b1;
                bus_we_o    = is_store;
                bus_addr_o  = {mem_addr_i[ADDR_W-1:2], 2'b00};
                bus_sel_o   = lane_sel;
                bus_wdata_o = is_store ? store_data : 32'd0;
                stall_req_o = 1'b1;
                we_reg_o    = 1'b0;
                whilo_o     = 1'b0;
                cnt_d       = cnt_q + 1'b1;
                if (bus_ack_i) begin
                    load_d  = load_fmt;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    load_d  = 32'd0;
                    tflag_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (is_load) begin
                    wdata_o = load_q;
                end
                timeout_o = tflag_q;
                tflag_d   = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            waddr_reg_o = NOP_REG_ADDR;
            we_reg_o    = 1'b0;
            wdata_o     = 32'd0;
            hi_o        = 32'd0;
            lo_o        = 32'd0;
            whilo_o     = 1'b0;
            stall_req_o = 1'b0;
            align_err_o = 1'b0;
            timeout_o   = 1'b0;
            bus_req_o   = 1'b0;
            bus_we_o    = 1'b0;
            bus_addr_o  = '0;
            bus_sel_o   = 4'b0000;
            bus_wdata_o = 32'd0;
        end
    end

    // State and capture registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            load_q  <= 32'd0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            tflag_q <= tflag_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed, table-driven bench for mem_lsu (built with TIMEOUT_CYC=8).
module tb_mem_lsu;

    localparam int AW = 32;
    localparam int RW = 5;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] waddr_reg_i;
    logic          we_reg_i;
    logic [31:0]   wdata_i;
    logic [31:0]   hi_i;
    logic [31:0]   lo_i;
    logic          whilo_i;
    logic [3:0]    mem_op_i;
    logic [AW-1:0] mem_addr_i;
    logic [31:0]   mem_sdata_i;
    logic          bus_req_o;
    logic          bus_we_o;
    logic [AW-1:0] bus_addr_o;
    logic [3:0]    bus_sel_o;
    logic [31:0]   bus_wdata_o;
    logic [31:0]   bus_rdata_i;
    logic          bus_ack_i;
    logic [RW-1:0] waddr_reg_o;
    logic          we_reg_o;
    logic [31:0]   wdata_o;
    logic [31:0]   hi_o;
    logic [31:0]   lo_o;
    logic          whilo_o;
    logic          stall_req_o;
    logic          align_err_o;
    logic          timeout_o;

    int total = 0;
    int bad   = 0;

    mem_lsu #(.ADDR_W(AW), .REG_ADDR_W(RW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .waddr_reg_i(waddr_reg_i), .we_reg_i(we_reg_i), .wdata_i(wdata_i),
        .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .waddr_reg_o(waddr_reg_o), .we_reg_o(we_reg_o), .wdata_o(wdata_o),
        .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
        .stall_req_o(stall_req_o), .align_err_o(align_err_o), .timeout_o(timeout_o)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] addr;
        logic        we;
        logic        whilo;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;
        logic        exp_align;
        logic        exp_we;
        logic        exp_whilo;
        logic [31:0] exp_wdata;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] wdata, input logic we, input logic [RW-1:0] waddr,
                                 input logic whilo);
        mem_op_i    = op;
        mem_addr_i  = addr;
        mem_sdata_i = sdata;
        wdata_i     = wdata;
        we_reg_i    = we;
        waddr_reg_i = waddr;
        whilo_i     = whilo;
        hi_i        = 32'hAAAA_0001;
        lo_i        = 32'h5555_0002;
    endtask

    task automatic runVector(input vec_t v);
        int  stalls;
        int  busy;
        logic done;
        @(negedge clk);
        applyStimulus(v.op, v.addr, 32'd0, v.wdata, v.we, 5'd7, v.whilo);
        bus_ack_i = 1'b0;
        #1;
        if (v.ack_at == 0) begin
            checkOutput({v.name, ".stall"}, 32'(stall_req_o), 32'd0);
            checkOutput({v.name, ".req"}, 32'(bus_req_o), 32'd0);
            checkOutput({v.name, ".align"}, 32'(align_err_o), 32'(v.exp_align));
            checkOutput({v.name, ".we"}, 32'(we_reg_o), 32'(v.exp_we));
            checkOutput({v.name, ".whilo"}, 32'(whilo_o), 32'(v.exp_whilo));
            checkOutput({v.name, ".wdata"}, wdata_o, v.exp_wdata);
            checkOutput({v.name, ".waddr"}, 32'(waddr_reg_o), 32'd7);
            checkOutput({v.name, ".hi"}, hi_o, 32'hAAAA_0001);
        end else begin
            checkOutput({v.name, ".idle_stall"}, 32'(stall_req_o), 32'd1);
            checkOutput({v.name, ".idle_req"}, 32'(bus_req_o), 32'd0);
            checkOutput({v.name, ".idle_we"}, 32'(we_reg_o), 32'd0);
            stalls = 1;
            busy   = 0;
            done   = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                @(negedge clk);
                bus_ack_i = 1'b0;
                #1;
                if (!stall_req_o) begin
                    done = 1'b1;
                end else begin
                    busy++;
                    stalls++;
                    if (busy == 1) begin
                        checkOutput({v.name, ".bus_addr"}, bus_addr_o, {v.addr[31:2], 2'b00});
                        checkOutput({v.name, ".bus_we"}, 32'(bus_we_o), 32'd0);
                    end
                    if (busy == v.ack_at) begin
                        bus_rdata_i = v.rdata;
                        bus_ack_i   = 1'b1;
                    end
                end
            end
            checkOutput({v.name, ".done_reached"}, 32'(done), 32'd1);
            checkOutput({v.name, ".stall_cycles"}, 32'(stalls), 32'(v.ack_at + 1));
            checkOutput({v.name, ".done_wdata"}, wdata_o, v.exp_wdata);
            checkOutput({v.name, ".done_we"}, 32'(we_reg_o), 32'(v.exp_we));
            checkOutput({v.name, ".done_req"}, 32'(bus_req_o), 32'd0);
            checkOutput({v.name, ".done_timeout"}, 32'(timeout_o), 32'd0);
        end
    endtask

    task automatic storeSeq(input string name, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [3:0] exp_sel, input logic [31:0] exp_bw);
        @(negedge clk);
        applyStimulus(op, addr, sdata, 32'h0000_0055, 1'b0, 5'd0, 1'b0);
        bus_ack_i = 1'b0;
        #1;
        checkOutput({name, ".idle_stall"}, 32'(stall_req_o), 32'd1);
        @(negedge clk);
        #1;
        checkOutput({name, ".req"}, 32'(bus_req_o), 32'd1);
        checkOutput({name, ".we"}, 32'(bus_we_o), 32'd1);
        checkOutput({name, ".sel"}, 32'(bus_sel_o), 32'(exp_sel));
        checkOutput({name, ".bus_wdata"}, bus_wdata_o, exp_bw);
        checkOutput({name, ".bus_addr"}, bus_addr_o, {addr[31:2], 2'b00});
        bus_ack_i = 1'b1;
        @(negedge clk);
        bus_ack_i = 1'b0;
        #1;
        checkOutput({name, ".done_stall"}, 32'(stall_req_o), 32'd0);
        checkOutput({name, ".done_wdata"}, wdata_o, 32'h0000_0055);
    endtask

    vec_t vecs[$];

    initial begin
        int reqs;
        logic done;

        // Table of single-cycle and load vectors; loads use rdata 0x80112233
        vecs.push_back('{"alu",    4'd0, 32'h0,   1'b1, 1'b1, 32'h1234, 32'h0, 0, 1'b0, 1'b1, 1'b1, 32'h1234});
        vecs.push_back('{"lw",     4'd5, 32'h100, 1'b1, 1'b0, 32'h9,    32'h80112233, 3, 1'b0, 1'b1, 1'b0, 32'h80112233});
        vecs.push_back('{"lb0",    4'd1, 32'h100, 1'b1, 1'b0, 32'h9,    32'h80112233, 1, 1'b0, 1'b1, 1'b0, 32'hFFFFFF80});
        vecs.push_back('{"lbu0",   4'd2, 32'h100, 1'b1, 1'b0, 32'h9,    32'h80112233, 2, 1'b0, 1'b1, 1'b0, 32'h00000080});
        vecs.push_back('{"lb3",    4'd1, 32'h103, 1'b1, 1'b0, 32'h9,    32'h80112233, 1, 1'b0, 1'b1, 1'b0, 32'h00000033});
        vecs.push_back('{"lh2",    4'd3, 32'h102, 1'b1, 1'b0, 32'h9,    32'h80112233, 1, 1'b0, 1'b1, 1'b0, 32'h00002233});
        vecs.push_back('{"lh0",    4'd3, 32'h100, 1'b1, 1'b0, 32'h9,    32'h80112233, 1, 1'b0, 1'b1, 1'b0, 32'hFFFF8011});
        vecs.push_back('{"lhu0",   4'd4, 32'h100, 1'b1, 1'b0, 32'h9,    32'h80112233, 1, 1'b0, 1'b1, 1'b0, 32'h00008011});
        vecs.push_back('{"lbu1",   4'd2, 32'h101, 1'b1, 1'b0, 32'h9,    32'h80112233, 1, 1'b0, 1'b1, 1'b0, 32'h00000011});
        vecs.push_back('{"lw_mis", 4'd5, 32'h102, 1'b1, 1'b1, 32'h77,   32'h0, 0, 1'b1, 1'b0, 1'b1, 32'h77});
        vecs.push_back('{"sh_mis", 4'd9, 32'h101, 1'b1, 1'b0, 32'h66,   32'h0, 0, 1'b1, 1'b0, 1'b0, 32'h66});
        vecs.push_back('{"op7",    4'd7, 32'h101, 1'b1, 1'b0, 32'h42,   32'h0, 0, 1'b0, 1'b1, 1'b0, 32'h42});

        // Reset with busy-looking inputs: every output must read zero
        rst         = 1'b1;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'd0;
        applyStimulus(4'd5, 32'h100, 32'hFFFF_FFFF, 32'h1234, 1'b1, 5'd5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst.waddr", 32'(waddr_reg_o), 32'd0);
        checkOutput("rst.we", 32'(we_reg_o), 32'd0);
        checkOutput("rst.wdata", wdata_o, 32'd0);
        checkOutput("rst.hilo", hi_o | lo_o, 32'd0);
        checkOutput("rst.ctl", {26'd0, whilo_o, stall_req_o, align_err_o, timeout_o, bus_req_o, bus_we_o}, 32'd0);
        mem_op_i = 4'd0;
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) runVector(vecs[i]);

        storeSeq("sh", 4'd9,  32'h102, 32'h0000_ABCD, 4'b0011, 32'hABCD_ABCD);
        storeSeq("sb", 4'd8,  32'h101, 32'h0000_00EE, 4'b0100, 32'hEEEE_EEEE);
        storeSeq("sw", 4'd10, 32'h104, 32'h1357_9BDF, 4'b1111, 32'h1357_9BDF);

        // Timeout: no ack ever; expect TO request cycles then DONE with timeout flagged
        @(negedge clk);
        applyStimulus(4'd5, 32'h200, 32'd0, 32'h9, 1'b1, 5'd4, 1'b0);
        bus_ack_i = 1'b0;
        reqs = 0;
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            #1;
            if (bus_req_o) reqs++;
            if (!stall_req_o) done = 1'b1;
        end
        checkOutput("to.done_reached", 32'(done), 32'd1);
        checkOutput("to.req_cycles", 32'(reqs), 32'(TO));
        checkOutput("to.timeout", 32'(timeout_o), 32'd1);
        checkOutput("to.wdata", wdata_o, 32'd0);
        checkOutput("to.we", 32'(we_reg_o), 32'd1);
        mem_op_i  = 4'd0;
        bus_ack_i = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("to.flag_cleared", 32'(timeout_o), 32'd0);
        checkOutput("to.late_ack_ignored", 32'(stall_req_o | bus_req_o), 32'd0);
        bus_ack_i = 1'b0;

        // Reset in the second BUSY cycle: outputs drop at once, IDLE afterwards
        @(negedge clk);
        applyStimulus(4'd5, 32'h300, 32'd0, 32'h9, 1'b1, 5'd6, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("rb.busy1_req", 32'(bus_req_o), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rb.req_drop", 32'(bus_req_o), 32'd0);
        checkOutput("rb.stall_drop", 32'(stall_req_o), 32'd0);
        checkOutput("rb.outs_zero", {wdata_o | hi_o | lo_o}, 32'd0);
        checkOutput("rb.waddr_zero", 32'(waddr_reg_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rb.idle_req", 32'(bus_req_o), 32'd0);
        checkOutput("rb.idle_stall", 32'(stall_req_o), 32'd1);
        mem_op_i = 4'd0;
        #1;
        checkOutput("rb.idle_pass", 32'(we_reg_o), 32'd1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
